// File: rtl/cordic_uart_bridge.sv
// ---------------------------------------------------------------------------
// cordic_uart_bridge
// Framing bridge between a byte-wide UART (RX/TX) and a pipelined CORDIC core.
//   RX: hunts for SYNC_BYTE, collects IN_BYTES payload bytes (plus an optional
//       XOR checksum byte), unpacks x/y/phase MSB-first and issues a
//       one-cycle cordic_enable. Issue is credit-limited so that the result
//       FIFO can never overflow.
//   TX: pops {res_x,res_y} from the result FIFO and sends
//       SYNC, OUT_BYTES data bytes MSB-first, then an optional XOR checksum.
// Ports:
//   clk, reset                       clock, async active-high reset
//   rx_dv, rx_byte                   byte strobe from UART_RX
//   tx_dv, tx_byte, tx_active,
//   tx_done                          handshake with UART_TX
//   cordic_enable/x/y/phase/aux      operand issue to the CORDIC
//   res_valid, res_x, res_y          results returned by the CORDIC
//   frame_err_cnt, drop_cnt          saturating error counters
//   busy                             any frame or result still in flight
// ---------------------------------------------------------------------------
module cordic_uart_bridge #(
  parameter int         XY_W        = 10,
  parameter int         PH_W        = 12,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter bit         CHK_EN      = 1'b1,
  parameter int         TIMEOUT_CYC = 100000,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_dv,
  input  logic [7:0]      rx_byte,
  output logic            tx_dv,
  output logic [7:0]      tx_byte,
  input  logic            tx_active,
  input  logic            tx_done,
  output logic            cordic_enable,
  output logic [XY_W-1:0] cordic_x,
  output logic [XY_W-1:0] cordic_y,
  output logic [PH_W-1:0] cordic_phase,
  output logic            cordic_aux,
  input  logic            res_valid,
  input  logic [XY_W-1:0] res_x,
  input  logic [XY_W-1:0] res_y,
  output logic [7:0]      frame_err_cnt,
  output logic [7:0]      drop_cnt,
  output logic            busy
);

  localparam int IN_BITS   = 2*XY_W + PH_W;
  localparam int IN_BYTES  = (IN_BITS + 7) / 8;
  localparam int IN_W      = IN_BYTES * 8;
  localparam int OUT_BITS  = 2*XY_W;
  localparam int OUT_BYTES = (OUT_BITS + 7) / 8;
  localparam int OUT_W     = OUT_BYTES * 8;
  localparam int OUT_PAD   = OUT_W - OUT_BITS;
  localparam int TX_LAST   = OUT_BYTES + (CHK_EN ? 1 : 0);
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W     = PTR_W + 1;

  typedef enum logic [1:0] {R_HUNT, R_PAYLOAD, R_CHECK} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_t;

  rx_state_t            rx_state_q, rx_state_d;
  logic [3:0]           rx_cnt_q, rx_cnt_d;
  logic [7:0]           rx_xor_q, rx_xor_d;
  logic [IN_W-1:0]      payload_q, payload_d;
  logic [31:0]          tmo_q, tmo_d;
  logic                 issue_q, issue_d;
  logic [XY_W-1:0]      cx_q, cx_d, cy_q, cy_d;
  logic [PH_W-1:0]      cph_q, cph_d;
  logic [OCC_W-1:0]     outst_q, outst_d;
  logic [7:0]           ferr_q, ferr_d, drop_q, drop_d;
  tx_state_t            tx_state_q, tx_state_d;
  logic [OUT_W-1:0]     tx_shift_q, tx_shift_d;
  logic [7:0]           tx_xor_q, tx_xor_d, tx_byte_q, tx_byte_d;
  logic [3:0]           tx_idx_q, tx_idx_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     fcnt_q, fcnt_d;
  logic [OUT_BITS-1:0]  fifo_mem [FIFO_DEPTH];

  logic accept, chk_fail, tmo_hit, drop_rx, drop_fifo, push, pop;
  logic fifo_full, fifo_empty;
  logic [OUT_BITS-1:0] fifo_rd;

  function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, v} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign fifo_full  = (fcnt_q == OCC_W'(FIFO_DEPTH));
  assign fifo_empty = (fcnt_q == '0);
  assign fifo_rd    = fifo_mem[rd_ptr_q];

  // RX framing: sync hunt, payload shift with running XOR, checksum compare,
  // inter-byte timeout. A byte arriving on the expiry cycle beats the timeout.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_xor_d   = rx_xor_q;
    payload_d  = payload_q;
    accept     = 1'b0;
    chk_fail   = 1'b0;
    tmo_hit    = 1'b0;
    if (rx_dv || rx_state_q == R_HUNT) tmo_d = '0;
    else                               tmo_d = tmo_q + 32'd1;
    case (rx_state_q)
      R_HUNT: begin
        if (rx_dv && rx_byte == SYNC_BYTE) begin
          rx_state_d = R_PAYLOAD;
          rx_cnt_d   = '0;
          rx_xor_d   = '0;
        end
      end
      R_PAYLOAD: begin
        if (rx_dv) begin
          payload_d = (payload_q << 8) | IN_W'(rx_byte);
          rx_xor_d  = rx_xor_q ^ rx_byte;
          rx_cnt_d  = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'(IN_BYTES - 1)) begin
            if (CHK_EN) rx_state_d = R_CHECK;
            else begin
              accept     = 1'b1;
              rx_state_d = R_HUNT;
            end
          end
        end
      end
      R_CHECK: begin
        if (rx_dv) begin
          rx_state_d = R_HUNT;
          if (rx_byte == rx_xor_q) accept   = 1'b1;
          else                     chk_fail = 1'b1;
        end
      end
      default: rx_state_d = R_HUNT;
    endcase
    if (TIMEOUT_CYC != 0 && !rx_dv && rx_state_q != R_HUNT &&
        tmo_q == 32'(TIMEOUT_CYC - 1)) begin
      tmo_hit    = 1'b1;
      rx_state_d = R_HUNT;
      tmo_d      = '0;
    end
  end

  // Issue only while a FIFO slot is reserved for the result; operands are
  // captured from the completed payload and held until the next issue.
  always_comb begin
    issue_d = accept && (outst_q < OCC_W'(FIFO_DEPTH));
    drop_rx = accept && !(outst_q < OCC_W'(FIFO_DEPTH));
    cx_d    = cx_q;
    cy_d    = cy_q;
    cph_d   = cph_q;
    if (issue_d) begin
      cx_d  = payload_d[IN_W-1 -: XY_W];
      cy_d  = payload_d[IN_W-1-XY_W -: XY_W];
      cph_d = payload_d[IN_W-1-2*XY_W -: PH_W];
    end
  end

  // TX framing: launch SYNC from idle, then one byte per tx_done.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_xor_d   = tx_xor_q;
    tx_byte_d  = tx_byte_q;
    tx_idx_d   = tx_idx_q;
    tx_dv_d    = 1'b0;
    pop        = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!fifo_empty && !tx_active) begin
          pop        = 1'b1;
          tx_shift_d = OUT_W'(fifo_rd) << OUT_PAD;
          tx_byte_d  = SYNC_BYTE;
          tx_dv_d    = 1'b1;
          tx_xor_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = T_WAIT;
        end
      end
      T_SEND: begin
        tx_dv_d    = 1'b1;
        tx_idx_d   = tx_idx_q + 4'd1;
        tx_state_d = T_WAIT;
        if (tx_idx_q < 4'(OUT_BYTES)) begin
          tx_byte_d  = tx_shift_q[OUT_W-1 -: 8];
          tx_xor_d   = tx_xor_q ^ tx_shift_q[OUT_W-1 -: 8];
          tx_shift_d = tx_shift_q << 8;
        end else begin
          tx_byte_d  = tx_xor_q;
        end
      end
      T_WAIT: begin
        if (tx_done) tx_state_d = (tx_idx_q == 4'(TX_LAST)) ? T_IDLE : T_SEND;
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // Result FIFO bookkeeping, credit tracking and saturating counters.
  always_comb begin
    push      = res_valid && !fifo_full;
    drop_fifo = res_valid && fifo_full;
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fcnt_d    = fcnt_q;
    if (push && !pop)      fcnt_d = fcnt_q + OCC_W'(1);
    else if (pop && !push) fcnt_d = fcnt_q - OCC_W'(1);
    outst_d = outst_q;
    if (issue_d && !pop)                      outst_d = outst_q + OCC_W'(1);
    else if (pop && !issue_d && outst_q != 0) outst_d = outst_q - OCC_W'(1);
    ferr_d = sat_add(ferr_q, {1'b0, chk_fail | tmo_hit});
    drop_d = sat_add(drop_q, {1'b0, drop_rx} + {1'b0, drop_fifo});
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {res_x, res_y};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= R_HUNT;
      rx_cnt_q   <= '0;
      rx_xor_q   <= '0;
      payload_q  <= '0;
      tmo_q      <= '0;
      issue_q    <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      cph_q      <= '0;
      outst_q    <= '0;
      ferr_q     <= '0;
      drop_q     <= '0;
      tx_state_q <= T_IDLE;
      tx_shift_q <= '0;
      tx_xor_q   <= '0;
      tx_byte_q  <= '0;
      tx_idx_q   <= '0;
      tx_dv_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_xor_q   <= rx_xor_d;
      payload_q  <= payload_d;
      tmo_q      <= tmo_d;
      issue_q    <= issue_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      cph_q      <= cph_d;
      outst_q    <= outst_d;
      ferr_q     <= ferr_d;
      drop_q     <= drop_d;
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_xor_q   <= tx_xor_d;
      tx_byte_q  <= tx_byte_d;
      tx_idx_q   <= tx_idx_d;
      tx_dv_q    <= tx_dv_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign cordic_enable = issue_q;
  assign cordic_aux    = issue_q;
  assign cordic_x      = cx_q;
  assign cordic_y      = cy_q;
  assign cordic_phase  = cph_q;
  assign tx_dv         = tx_dv_q;
  assign tx_byte       = tx_byte_q;
  assign frame_err_cnt = ferr_q;
  assign drop_cnt      = drop_q;
  assign busy          = (rx_state_q != R_HUNT) || (tx_state_q != T_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_cordic_uart_bridge.sv
// ---------------------------------------------------------------------------
// tb_cordic_uart_bridge
// Directed bench for cordic_uart_bridge (TIMEOUT_CYC=1000, FIFO_DEPTH=2).
// A behavioural UART_TX model records transmitted bytes; a CORDIC stand-in
// answers every issue one cycle later with the result held in resX/resY.
// ---------------------------------------------------------------------------
module tb_cordic_uart_bridge;

  localparam int XY_W = 10;
  localparam int PH_W = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            rx_dv = 1'b0;
  logic [7:0]      rx_byte = 8'h00;
  logic            tx_dv;
  logic [7:0]      tx_byte;
  logic            tx_active = 1'b0;
  logic            tx_done = 1'b0;
  logic            cordic_enable;
  logic [XY_W-1:0] cordic_x, cordic_y;
  logic [PH_W-1:0] cordic_phase;
  logic            cordic_aux;
  logic            res_valid = 1'b0;
  logic [XY_W-1:0] res_x = '0, res_y = '0;
  logic [7:0]      frame_err_cnt, drop_cnt;
  logic            busy;

  always #5 clk = ~clk;

  cordic_uart_bridge #(
    .XY_W(XY_W), .PH_W(PH_W), .SYNC_BYTE(8'hA5), .CHK_EN(1'b1),
    .TIMEOUT_CYC(1000), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
    .cordic_enable(cordic_enable), .cordic_x(cordic_x), .cordic_y(cordic_y),
    .cordic_phase(cordic_phase), .cordic_aux(cordic_aux),
    .res_valid(res_valid), .res_x(res_x), .res_y(res_y),
    .frame_err_cnt(frame_err_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // CORDIC stand-in and issue monitor
  logic [XY_W-1:0] resX = '0, resY = '0;
  logic [XY_W-1:0] lastX = '0, lastY = '0;
  logic [PH_W-1:0] lastPh = '0;
  logic            lastAux = 1'b0;
  logic            prevEnable = 1'b0;
  int              enableCnt = 0;
  int              outAtIssue = 0;

  always @(negedge clk) begin
    if (reset) begin
      res_valid  = 1'b0;
      prevEnable = 1'b0;
    end else begin
      res_valid = 1'b0;
      if (cordic_enable) begin
        checkOutput("enable_width", {31'b0, prevEnable}, 32'd0);
        enableCnt++;
        lastX      = cordic_x;
        lastY      = cordic_y;
        lastPh     = cordic_phase;
        lastAux    = cordic_aux;
        outAtIssue = int'(dut.outst_q);
        res_valid  = 1'b1;
        res_x      = resX;
        res_y      = resY;
      end
      prevEnable = cordic_enable;
    end
  end

  // UART_TX model: each byte keeps the line busy for a few cycles
  logic [7:0] txq[$];
  logic       mBusy = 1'b0;
  logic       holdActive = 1'b0;
  int         mCnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      mBusy   = 1'b0;
      mCnt    = 0;
      tx_done = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (tx_dv) begin
        checkOutput("tx_dv_gap", {31'b0, mBusy}, 32'd0);
        txq.push_back(tx_byte);
        mBusy = 1'b1;
        mCnt  = 3;
      end else if (mBusy) begin
        if (mCnt == 0) begin
          tx_done = 1'b1;
          mBusy   = 1'b0;
        end else mCnt--;
      end
    end
    tx_active = mBusy | holdActive;
  end

  task automatic applyStimulus(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b0, b1, b2, b3, input bit corrupt);
    logic [7:0] chk;
    chk = b0 ^ b1 ^ b2 ^ b3 ^ {7'b0, corrupt};
    applyStimulus(8'hA5);
    applyStimulus(b0);
    applyStimulus(b1);
    applyStimulus(b2);
    applyStimulus(b3);
    applyStimulus(chk);
  endtask

  task automatic waitEnables(input int n);
    for (int i = 0; i < 200 && enableCnt < n; i++) @(negedge clk);
    checkOutput("enable_count", enableCnt, n);
  endtask

  task automatic waitBytes(input int n);
    for (int i = 0; i < 2000 && txq.size() < n; i++) @(negedge clk);
    checkOutput("tx_count", txq.size(), n);
  endtask

  task automatic checkTx(input string tag, input int base,
                         input logic [7:0] e0, e1, e2, e3, e4);
    logic [7:0] exp [5];
    logic [7:0] got;
    exp = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < 5; i++) begin
      got = (base + i < txq.size()) ? txq[base + i] : 8'hxx;
      checkOutput($sformatf("%s[%0d]", tag, i), {24'b0, got}, {24'b0, exp[i]});
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_dv", {31'b0, tx_dv}, 0);
    checkOutput("rst_tx_byte", {24'b0, tx_byte}, 0);
    checkOutput("rst_enable", {31'b0, cordic_enable}, 0);
    checkOutput("rst_aux", {31'b0, cordic_aux}, 0);
    checkOutput("rst_ferr", {24'b0, frame_err_cnt}, 0);
    checkOutput("rst_drop", {24'b0, drop_cnt}, 0);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic round trip
    resX = 10'h3FF; resY = 10'h001;
    sendFrame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    waitEnables(1);
    checkOutput("op_x", {22'b0, lastX}, 32'h048);
    checkOutput("op_y", {22'b0, lastY}, 32'h345);
    checkOutput("op_phase", {20'b0, lastPh}, 32'h678);
    checkOutput("op_aux", {31'b0, lastAux}, 1);
    checkOutput("outst_at_issue", outAtIssue, 1);
    waitBytes(5);
    checkTx("tx1", 0, 8'hA5, 8'hFF, 8'hC0, 8'h10, 8'h2F);
    repeat (10) @(negedge clk);
    checkOutput("busy_after_tx1", {31'b0, busy}, 0);
    checkOutput("outst_after_tx1", int'(dut.outst_q), 0);
    checkOutput("op_x_hold", {22'b0, cordic_x}, 32'h048);

    // Bad checksum, then a good frame
    txq.delete();
    sendFrame(8'h12, 8'h34, 8'h56, 8'h78, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("bad_chk_no_issue", enableCnt, 1);
    checkOutput("bad_chk_ferr", {24'b0, frame_err_cnt}, 1);
    resX = 10'h2AA; resY = 10'h155;
    sendFrame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    waitEnables(2);
    waitBytes(5);
    checkTx("tx2", 0, 8'hA5, 8'hAA, 8'h95, 8'h50, 8'h6F);
    checkOutput("ferr_after_good", {24'b0, frame_err_cnt}, 1);

    // Inter-byte timeout expires, then a 999-cycle gap is tolerated
    txq.delete();
    applyStimulus(8'hA5);
    applyStimulus(8'h12);
    repeat (500) @(negedge clk);
    checkOutput("busy_mid_frame", {31'b0, busy}, 1);
    repeat (503) @(negedge clk);
    checkOutput("tmo_ferr", {24'b0, frame_err_cnt}, 2);
    checkOutput("tmo_busy", {31'b0, busy}, 0);
    resX = 10'h000; resY = 10'h000;
    applyStimulus(8'hA5);
    applyStimulus(8'h12);
    repeat (997) @(negedge clk);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    applyStimulus(8'h78);
    applyStimulus(8'h08);
    waitEnables(3);
    checkOutput("gap999_ferr", {24'b0, frame_err_cnt}, 2);
    waitBytes(5);
    checkTx("tx3", 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);

    // Credit exhaustion with the transmitter held busy
    repeat (10) @(negedge clk);
    txq.delete();
    holdActive = 1'b1;
    repeat (2) @(negedge clk);
    resX = 10'h001; resY = 10'h002;
    sendFrame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    waitEnables(4);
    resX = 10'h003; resY = 10'h004;
    sendFrame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    waitEnables(5);
    resX = 10'h005; resY = 10'h006;
    sendFrame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("credit_enables", enableCnt, 5);
    checkOutput("credit_drop", {24'b0, drop_cnt}, 1);
    checkOutput("credit_busy", {31'b0, busy}, 1);
    checkOutput("credit_no_tx", txq.size(), 0);
    holdActive = 1'b0;
    waitBytes(10);
    checkTx("tx4a", 0, 8'hA5, 8'h00, 8'h40, 8'h20, 8'h60);
    checkTx("tx4b", 5, 8'hA5, 8'h00, 8'hC0, 8'h40, 8'h80);
    repeat (10) @(negedge clk);
    checkOutput("credit_idle", {31'b0, busy}, 0);

    // Reset in the middle of a TX frame
    txq.delete();
    resX = 10'h3FF; resY = 10'h001;
    sendFrame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    waitBytes(3);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_tx_dv", {31'b0, tx_dv}, 0);
    checkOutput("mid_rst_tx_byte", {24'b0, tx_byte}, 0);
    checkOutput("mid_rst_x", {22'b0, cordic_x}, 0);
    checkOutput("mid_rst_ferr", {24'b0, frame_err_cnt}, 0);
    checkOutput("mid_rst_drop", {24'b0, drop_cnt}, 0);
    checkOutput("mid_rst_busy", {31'b0, busy}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    txq.delete();
    repeat (30) @(negedge clk);
    checkOutput("post_rst_no_tx", txq.size(), 0);
    resX = 10'h2AA; resY = 10'h155;
    sendFrame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    waitBytes(5);
    checkTx("tx5", 0, 8'hA5, 8'hAA, 8'h95, 8'h50, 8'h6F);
    checkOutput("post_rst_ferr", {24'b0, frame_err_cnt}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cordic_uart_bridge.md
Name: cordic_uart_bridge

Overview:
Parametrised framing bridge between the UART byte interfaces (UART_RX/UART_TX) and a pipelined CORDIC core (Cordic_Algoo).
- RX side: receives SYNC-delimited, optionally checksummed operand frames; unpacks generic-width x/y/phase fields; issues one-cycle CORDIC enables.
- TX side: buffers CORDIC results in a FIFO; re-frames them and transmits them byte by byte.
- New capabilities: configurable widths, frame sync, XOR checksum, inter-byte timeout, credit-based overflow protection, error counters.

Parameters:
XY_W, 10, width of x/y operands and results (2..16)
PH_W, 12, width of phase operand (2..16)
SYNC_BYTE, 8'hA5, frame header byte, both directions
CHK_EN, 1, 1 = XOR checksum byte appended to RX and TX frames
TIMEOUT_CYC, 100000, max clk cycles between RX bytes inside a frame; 0 disables the timeout
FIFO_DEPTH, 4, result FIFO entries, power of 2 (2..16)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_dv  in  1  one-cycle strobe, rx_byte valid
rx_byte  in  8  received byte
tx_dv  out  1  one-cycle strobe to UART_TX, launches tx_byte
tx_byte  out  8  byte to transmit, stable from the tx_dv cycle until tx_done
tx_active  in  1  UART_TX busy
tx_done  in  1  one-cycle strobe, byte finished
cordic_enable  out  1  one-cycle operand issue strobe
cordic_x  out  XY_W  x operand
cordic_y  out  XY_W  y operand
cordic_phase  out  PH_W  phase operand
cordic_aux  out  1  driven 1 on every issue; 0 otherwise
res_valid  in  1  CORDIC aux_out; one-cycle pulse per issued operand
res_x  in  XY_W  CORDIC x result
res_y  in  XY_W  CORDIC y result
frame_err_cnt  out  8  saturating count of checksum failures and timeouts
drop_cnt  out  8  saturating count of valid frames dropped for lack of credit
busy  out  1  RX FSM not in R_HUNT, or TX FSM not in T_IDLE, or FIFO not empty

Behaviour:
- Reset: all outputs 0; both FSMs idle; FIFO empty; outstanding = 0; counters 0. Reset mid-frame aborts with no partial TX byte strobe afterwards.
- Derived widths:
  - IN_BITS = 2*XY_W+PH_W; IN_BYTES = ceil(IN_BITS/8).
  - OUT_BITS = 2*XY_W; OUT_BYTES = ceil(OUT_BITS/8).
  - Fields are packed MSB-first, pad bits are in the LSBs; RX pad is ignored, TX pad is 0.
- RX FSM states: R_HUNT, R_PAYLOAD, R_CHECK.
  - R_HUNT: a byte equal to SYNC_BYTE -> R_PAYLOAD, with byte count = 0 and xor = 0. Any other byte is ignored, with no error.
  - R_PAYLOAD: shift the byte into the payload register and xor it into the running xor. After byte IN_BYTES -> R_CHECK if CHK_EN, else accept.
  - R_CHECK: byte equal to the running xor -> accept; otherwise frame_err_cnt++ -> R_HUNT.
  - A SYNC_BYTE value inside the payload is data, not a resync.
- Accept:
  - If outstanding < FIFO_DEPTH: the cycle after the accepting rx_dv, cordic_enable = 1 for exactly one cycle, and outstanding++.
  - On that cycle, cordic_x = payload[IN_BYTES*8-1 -: XY_W], cordic_y = the next XY_W bits, cordic_phase = the next PH_W bits.
  - Operands hold until the next issue.
  - Otherwise: no issue, drop_cnt++.
  - In both cases -> R_HUNT.
- Timeout:
  - The counter clears on every rx_dv and counts in R_PAYLOAD/R_CHECK.
  - Reaching TIMEOUT_CYC -> R_HUNT and frame_err_cnt++.
  - If rx_dv coincides with the expiry, the byte wins and the timeout is discarded.
- Result FIFO:
  - Each res_valid pushes {res_x,res_y}.
  - The credit scheme guarantees no overflow. If a push arrives when the FIFO is full (CORDIC misbehaviour), the push is dropped and drop_cnt++.
  - outstanding-- on each pop. Simultaneous issue and pop leaves outstanding unchanged.
- TX FSM states: T_IDLE, T_SEND, T_WAIT.
  - T_IDLE: if FIFO not empty and ~tx_active: pop the entry into the shift register, tx_byte = SYNC_BYTE, tx_dv = 1, xor = 0 -> T_WAIT.
  - T_WAIT: on tx_done -> T_SEND, or -> T_IDLE if the final byte is done.
  - T_SEND: present the next byte, with tx_dv for one cycle -> T_WAIT.
  - Byte sequence: SYNC, OUT_BYTES data bytes MSB-first, then the xor of the data bytes if CHK_EN (SYNC is excluded from the xor).
  - tx_dv is never asserted while tx_active = 1 at the IDLE launch. Between bytes, launch is gated only on tx_done.
- Counters saturate at 255.
- RX and TX run independently. Full-duplex overlap is required.

Test Plan:
- Defaults. RX A5,12,34,56,78,08 -> one cordic_enable pulse with cordic_x=10'h048, cordic_y=10'h345, cordic_phase=12'h678, cordic_aux=1; outstanding=1.
- res_valid with res_x=10'h3FF, res_y=10'h001 -> TX bytes A5,FF,C0,10,2F, each tx_dv single-cycle and only after the preceding tx_done; outstanding returns to 0.
- RX A5,12,34,56,78,09 (bad checksum) -> no cordic_enable, frame_err_cnt=1; a following correct frame is issued normally.
- TIMEOUT_CYC=1000: RX A5,12, then idle 1000 cycles -> RX FSM in R_HUNT, frame_err_cnt=1. Repeat with the next byte at cycle 999 -> frame continues.
- FIFO_DEPTH=2, tx_active held high, three valid frames with results returned -> exactly 2 enables, drop_cnt=1. Release tx_active -> two 5-byte TX frames, in order.
- Assert reset during the third TX byte -> all outputs 0 next cycle, FIFO empty, no further tx_dv; a post-reset frame round-trips correctly.
